// File: rtl/nrzi_tx.sv
// nrzi_tx - USB transmit-side line encoder.
//
// Takes raw serial bits from the packet layer, optionally inserts bit
// stuffing, NRZI-encodes the stream and appends the end-of-packet sequence
// (SE0, SE0, J). One line bit is produced per clock.
//
// Build option:
//   NRZI_TX_STUFF_EN  defined   : a stuffed 0 follows every STUFF_LEN
//                                  consecutive transmitted 1s.
//                     undefined : no stuffing logic, runs of 1s pass unchanged
//                                  (line-coding tests only).
//
// Parameters:
//   STUFF_LEN       run length of 1s that forces a stuffed 0 (default 6)
//
// Ports:
//   clk             system clock, one line bit per cycle
//   rst_b           asynchronous active-low reset
//   bstr_in         raw data bit
//   bstr_in_ready   bstr_in valid this cycle
//   in_done         last data bit has been sent, request EOP
//   stall           upstream must hold its inputs (combinational from state)
//   bstr_out        NRZI line level, J = 1, K = 0
//   bstr_out_ready  bstr_out / se0 drive the line this cycle
//   se0             drive SE0 (bstr_out is don't-care)
//   out_done        one-cycle pulse after the EOP J cycle
module nrzi_tx #(
    parameter int STUFF_LEN = 6
) (
    input  logic clk,
    input  logic rst_b,
    input  logic bstr_in,
    input  logic bstr_in_ready,
    input  logic in_done,
    output logic stall,
    output logic bstr_out,
    output logic bstr_out_ready,
    output logic se0,
    output logic out_done
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DATA  = 3'd1,
        ST_SE0_A = 3'd2,
        ST_SE0_B = 3'd3,
        ST_EOP_J = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic r_level;
    logic w_level_nxt;
    logic r_done_pend;
    logic w_done_pend_nxt;
    logic r_bstr_out;
    logic w_bstr_out_nxt;
    logic r_out_ready;
    logic w_out_ready_nxt;
    logic r_se0;
    logic w_se0_nxt;
    logic r_out_done;
    logic w_out_done_nxt;

    logic w_stuff;      // this edge emits a stuffed 0
    logic w_eop_state;  // one of the three EOP states
    logic w_bit_acc;    // data bit handshake completes on this edge
    logic w_done_acc;   // in_done handshake completes on this edge
    logic w_enc_en;     // accepted data bit is actually encoded on this edge
    logic w_enc_level;  // line level after NRZI-encoding bstr_in

    // A zero-length run would stuff forever; refuse to elaborate.
    generate
        if (STUFF_LEN < 1) begin : g_bad_stuff_len
            $error("nrzi_tx: STUFF_LEN must be at least 1");
        end
    endgenerate

    assign w_eop_state = (r_state == ST_SE0_A) || (r_state == ST_SE0_B) ||
                         (r_state == ST_EOP_J);
    assign stall       = w_stuff || w_eop_state;
    assign w_bit_acc   = bstr_in_ready && !stall;
    assign w_done_acc  = in_done && !stall;
    // Once EOP is pending, the next non-stuff edge belongs to EOP entry.
    assign w_enc_en    = w_bit_acc &&
                         ((r_state == ST_IDLE) ||
                          ((r_state == ST_DATA) && !r_done_pend));
    // NRZI: a 0 toggles the line, a 1 holds it.
    assign w_enc_level = r_level ^ ~bstr_in;

`ifdef NRZI_TX_STUFF_EN
    localparam int CW = $clog2(STUFF_LEN + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(STUFF_LEN);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    logic [CW-1:0] r_ones_cnt;
    logic [CW-1:0] w_ones_cnt_nxt;

    assign w_stuff = (r_state == ST_DATA) && (r_ones_cnt == CNT_MAX);

    // Run-of-ones counter: cleared by a 0, a stuffed bit or end of packet.
    always_comb begin
        w_ones_cnt_nxt = r_ones_cnt;
        if (r_state == ST_EOP_J) begin
            w_ones_cnt_nxt = CNT_ZERO;
        end else if (w_stuff) begin
            w_ones_cnt_nxt = CNT_ZERO;
        end else if (w_enc_en) begin
            if (bstr_in) begin
                w_ones_cnt_nxt = r_ones_cnt + CNT_ONE;
            end else begin
                w_ones_cnt_nxt = CNT_ZERO;
            end
        end else begin
            w_ones_cnt_nxt = r_ones_cnt;
        end
    end

    // Run-of-ones counter register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_ones_cnt <= CNT_ZERO;
        end else begin
            r_ones_cnt <= w_ones_cnt_nxt;
        end
    end
`else
    assign w_stuff = 1'b0;
`endif

    // State, line level and output registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state     <= ST_IDLE;
            r_level     <= 1'b1;
            r_done_pend <= 1'b0;
            r_bstr_out  <= 1'b1;
            r_out_ready <= 1'b0;
            r_se0       <= 1'b0;
            r_out_done  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_level     <= w_level_nxt;
            r_done_pend <= w_done_pend_nxt;
            r_bstr_out  <= w_bstr_out_nxt;
            r_out_ready <= w_out_ready_nxt;
            r_se0       <= w_se0_nxt;
            r_out_done  <= w_out_done_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_bit_acc) begin
                    w_state_nxt = ST_DATA;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (w_stuff) begin
                    w_state_nxt = ST_DATA;
                end else if (r_done_pend) begin
                    w_state_nxt = ST_SE0_A;
                end else if (w_bit_acc) begin
                    w_state_nxt = ST_DATA;
                end else if (w_done_acc) begin
                    w_state_nxt = ST_SE0_A;
                end else begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_SE0_A: w_state_nxt = ST_SE0_B;
            ST_SE0_B: w_state_nxt = ST_EOP_J;
            ST_EOP_J: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the line level, EOP-pending flag and registered outputs.
    always_comb begin
        w_level_nxt     = r_level;
        w_done_pend_nxt = r_done_pend;
        w_bstr_out_nxt  = r_bstr_out;
        w_out_ready_nxt = 1'b0;
        w_se0_nxt       = 1'b0;
        w_out_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // in_done is ignored here; only a data bit starts a packet.
                if (w_enc_en) begin
                    w_level_nxt     = w_enc_level;
                    w_bstr_out_nxt  = w_enc_level;
                    w_out_ready_nxt = 1'b1;
                end else begin
                    w_bstr_out_nxt  = 1'b1;
                end
            end
            ST_DATA: begin
                if (w_stuff) begin
                    w_level_nxt     = ~r_level;
                    w_bstr_out_nxt  = ~r_level;
                    w_out_ready_nxt = 1'b1;
                end else if (r_done_pend) begin
                    w_se0_nxt       = 1'b1;
                    w_out_ready_nxt = 1'b1;
                end else if (w_enc_en) begin
                    w_level_nxt     = w_enc_level;
                    w_bstr_out_nxt  = w_enc_level;
                    w_out_ready_nxt = 1'b1;
                    w_done_pend_nxt = w_done_acc;
                end else if (w_done_acc) begin
                    w_se0_nxt       = 1'b1;
                    w_out_ready_nxt = 1'b1;
                end else begin
                    // Upstream gap: line is not driven, level is held.
                    w_out_ready_nxt = 1'b0;
                end
            end
            ST_SE0_A: begin
                w_se0_nxt       = 1'b1;
                w_out_ready_nxt = 1'b1;
            end
            ST_SE0_B: begin
                w_bstr_out_nxt  = 1'b1;
                w_out_ready_nxt = 1'b1;
            end
            ST_EOP_J: begin
                w_bstr_out_nxt  = 1'b1;
                w_out_done_nxt  = 1'b1;
                w_level_nxt     = 1'b1;
                w_done_pend_nxt = 1'b0;
            end
            default: begin
                w_bstr_out_nxt  = 1'b1;
                w_level_nxt     = 1'b1;
                w_done_pend_nxt = 1'b0;
            end
        endcase
    end

    assign bstr_out       = r_bstr_out;
    assign bstr_out_ready = r_out_ready;
    assign se0            = r_se0;
    assign out_done       = r_out_done;

endmodule

// File: tb/tb_nrzi_tx.sv
// Self-checking bench for nrzi_tx. Packets are described as bit lists; a
// behavioural model turns each packet into a per-edge list of what upstream
// drives and what the line must show, then a driver replays the list and a
// single compare process checks the DUT on every cycle.
module tb_nrzi_tx;
    localparam int STUFF_LEN = 6;
`ifdef NRZI_TX_STUFF_EN
    localparam bit STUFF_EN = 1'b1;
`else
    localparam bit STUFF_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_b;
    logic bstr_in;
    logic bstr_in_ready;
    logic in_done;
    logic stall;
    logic bstr_out;
    logic bstr_out_ready;
    logic se0;
    logic out_done;

    int checks = 0;
    int errors = 0;

    // One entry per clock edge: upstream drive, stall during that cycle,
    // line outputs after that edge.
    typedef struct packed {
        logic drv_rdy;
        logic drv_bit;
        logic drv_done;
        logic drv_rst;
        logic stall;
        logic rdy;
        logic se0;
        logic out;
        logic out_chk;
        logic done;
    } edge_t;

    edge_t q[$];
    bit    pk[$];

    nrzi_tx #(.STUFF_LEN(STUFF_LEN)) dut (
        .clk            (clk),
        .rst_b          (rst_b),
        .bstr_in        (bstr_in),
        .bstr_in_ready  (bstr_in_ready),
        .in_done        (in_done),
        .stall          (stall),
        .bstr_out       (bstr_out),
        .bstr_out_ready (bstr_out_ready),
        .se0            (se0),
        .out_done       (out_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0d: got %0d expected %0d", name, idx, got, exp);
        end
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic d_rdy, input logic d_bit, input logic d_done,
                        input logic d_rst, input logic e_stall, input logic e_rdy,
                        input logic e_se0, input logic e_out, input logic e_chk,
                        input logic e_done);
        edge_t e;
        e.drv_rdy  = d_rdy;
        e.drv_bit  = d_bit;
        e.drv_done = d_done;
        e.drv_rst  = d_rst;
        e.stall    = e_stall;
        e.rdy      = e_rdy;
        e.se0      = e_se0;
        e.out      = e_out;
        e.out_chk  = e_chk;
        e.done     = e_done;
        q.push_back(e);
    endtask

    task automatic push_idle(input int n);
        for (int k = 0; k < n; k++) push(1'b0, rbit(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic set_sync();
        pk.delete();
        for (int j = 0; j < 7; j++) pk.push_back(1'b0);
        pk.push_back(1'b1);
    endtask

    task automatic add_ones(input int n);
        for (int j = 0; j < n; j++) pk.push_back(1'b1);
    endtask

    // Behavioural model: NRZI level starts at J, a 0 flips it, every
    // STUFF_LEN-th consecutive 1 is followed by an extra flip during which
    // upstream holds its next item. in_done (alone or with the last bit)
    // leads to SE0, SE0, J and a done pulse; abort replaces SE0_A by reset.
    task automatic add_packet(input int gap_at, input int gap_len, input bit dwl,
                              input bit abort);
        logic level;
        int   ones;
        int   n;
        bit   last;
        logic h_rdy;
        logic h_bit;
        logic h_done;
        level = 1'b1;
        ones  = 0;
        n     = pk.size();
        for (int i = 0; i < n; i++) begin
            last = (i == n - 1);
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++)
                    push(1'b0, rbit(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            end
            level = pk[i] ? level : ~level;
            ones  = pk[i] ? ones + 1 : 0;
            push(1'b1, pk[i], last && dwl, 1'b0, 1'b0, 1'b1, 1'b0, level, 1'b1, 1'b0);
            if (STUFF_EN && ones == STUFF_LEN) begin
                ones  = 0;
                level = ~level;
                if (!last && (i + 1) != gap_at) begin
                    h_rdy = 1'b1; h_bit = pk[i+1]; h_done = ((i + 1) == (n - 1)) && dwl;
                end else if (last && !dwl) begin
                    h_rdy = 1'b0; h_bit = rbit(); h_done = 1'b1;
                end else begin
                    h_rdy = 1'b0; h_bit = rbit(); h_done = 1'b0;
                end
                push(h_rdy, h_bit, h_done, 1'b0, 1'b1, 1'b1, 1'b0, level, 1'b1, 1'b0);
            end
        end
        push(1'b0, rbit(), !dwl, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        if (abort) begin
            push(1'b0, rbit(), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        end else begin
            push(1'b0, rbit(), 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            push(1'b0, rbit(), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
            push(1'b0, rbit(), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        end
    endtask

    function automatic int cnt_stall(input int s, input int e);
        int c = 0;
        for (int k = s; k < e; k++) if (q[k].stall) c++;
        return c;
    endfunction

    function automatic int cnt_rdy(input int s, input int e, input bit val);
        int c = 0;
        for (int k = s; k < e; k++) if (q[k].rdy == val) c++;
        return c;
    endfunction

    initial begin
        int s;
        int e;
        int ga;
        int nd;
        int n_rec;
        logic [7:0] sync_exp;

        rst_b = 1'b0; bstr_in = 1'b0; bstr_in_ready = 1'b0; in_done = 1'b0;

        push_idle(3);

        // SYNC then in_done alone.
        s = q.size(); set_sync(); add_packet(-1, 0, 1'b0, 1'b0); e = q.size();
        sync_exp = 8'b0010_1010;
        for (int i = 0; i < 8; i++) chk("model_sync_level", i, 32'(q[s+i].out), 32'(sync_exp[i]));
        chk("model_sync_ready_cycles", s, cnt_rdy(s, e, 1'b1), 11);
        chk("model_sync_done_pos", s + 11, 32'(q[s+11].done), 1);
        push_idle(2);

        // SYNC + eight 1s: the SYNC's final 1 starts the run.
        s = q.size(); set_sync(); add_ones(8); add_packet(-1, 0, 1'b0, 1'b0); e = q.size();
        chk("model_stuff_stalls", s, cnt_stall(s, e) - 3, 32'(STUFF_EN));
        chk("model_stuff_level", s + 13, 32'(q[s+13].out), 32'(STUFF_EN));
        push_idle(1);

        // in_done with the bit that triggers stuffing.
        s = q.size(); set_sync(); add_ones(5); add_packet(-1, 0, 1'b1, 1'b0); e = q.size();
        chk("model_done_stuff_len", s, e - s, 8 + 5 + 32'(STUFF_EN) + 4);
        push_idle(2);

        // Gap of three mid-run, stuffing still follows the sixth 1.
        s = q.size(); set_sync(); add_ones(3); add_ones(2);
        add_packet(11, 3, 1'b0, 1'b0); e = q.size();
        chk("model_gap_ready_low", s, cnt_rdy(s, e, 1'b0), 4);
        chk("model_gap_stalls", s, cnt_stall(s, e) - 3, 32'(STUFF_EN));
        push_idle(1);

        // Reset during SE0_A, then a packet of leading 1s from a clean state.
        set_sync(); add_ones(4); add_packet(-1, 0, 1'b0, 1'b1);
        push_idle(2);
        s = q.size(); pk.delete(); add_ones(5); pk.push_back(1'b0); pk.push_back(1'b1);
        add_packet(-1, 0, 1'b1, 1'b0); e = q.size();
        chk("model_after_rst_level", s, 32'(q[s].out), 1);
        chk("model_after_rst_stalls", s, cnt_stall(s, e) - 3, 0);
        push_idle(1);

        // Long run of ones.
        s = q.size(); set_sync(); add_ones(10); add_packet(-1, 0, 1'b0, 1'b0); e = q.size();
        chk("model_ten_ones_stalls", s, cnt_stall(s, e) - 3, 32'(STUFF_EN));
        push_idle(2);

        // Random packets, biased towards 1s to provoke stuffing.
        for (int p = 0; p < 20; p++) begin
            set_sync();
            nd = $urandom_range(0, 30);
            for (int j = 0; j < nd; j++) pk.push_back($urandom_range(0, 3) != 0);
            ga = ($urandom_range(0, 1) == 1) ? $urandom_range(1, pk.size() - 1) : -1;
            add_packet(ga, $urandom_range(1, 3), 1'($urandom_range(0, 1)), 1'b0);
            push_idle($urandom_range(0, 3));
        end
        push_idle(2);

        n_rec = q.size();
        fork
            begin : driver
                for (int i = 0; i < n_rec; i++) begin
                    @(negedge clk);
                    rst_b         = ~q[i].drv_rst;
                    bstr_in_ready = q[i].drv_rdy;
                    bstr_in       = q[i].drv_bit;
                    in_done       = q[i].drv_done;
                end
                @(negedge clk);
                bstr_in_ready = 1'b0;
                in_done       = 1'b0;
            end
            begin : compare
                for (int i = 0; i < n_rec; i++) begin
                    @(negedge clk);
                    #2;
                    chk("stall", i, 32'(stall), 32'(q[i].stall));
                    if (q[i].drv_rst) begin
                        chk("rst_bstr_out", i, 32'(bstr_out), 1);
                        chk("rst_ready", i, 32'(bstr_out_ready), 0);
                        chk("rst_se0", i, 32'(se0), 0);
                        chk("rst_out_done", i, 32'(out_done), 0);
                    end
                    @(posedge clk);
                    #2;
                    chk("ready", i, 32'(bstr_out_ready), 32'(q[i].rdy));
                    chk("se0", i, 32'(se0), 32'(q[i].se0));
                    chk("out_done", i, 32'(out_done), 32'(q[i].done));
                    if (q[i].out_chk) chk("bstr_out", i, 32'(bstr_out), 32'(q[i].out));
                end
            end
        join

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
